// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the SWIPT receive PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } pll_state_t;

    localparam int CNT_W   = 32;
    localparam int QUAL_W  = 8;
    localparam int RETRY_W = 2;

    localparam logic [31:0] DEF_LOCK_THR   = 32'd50;
    localparam logic [31:0] DEF_UNLOCK_THR = 32'd200;
    localparam logic [31:0] DEF_F_MIN      = 32'd30000;
    localparam logic [31:0] DEF_F_MAX      = 32'd60000;

    // Down-count that holds at zero instead of wrapping
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b0}}) begin
            return v;
        end else begin
            return v - 32'd1;
        end
    endfunction

endpackage

// File: rtl/lock_qualifier.sv
// Counts consecutive phase-error samples on one side of a threshold and
// pulses hit on the sample that completes the required run.
module lock_qualifier
    import pll_seq_pkg::*;
#(
    parameter logic [31:0] THR   = DEF_LOCK_THR,
    parameter int          CNT   = 8,
    parameter bit          ABOVE = 1'b0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        clr,
    input  logic        sample_vld,
    input  logic [31:0] sample,
    output logic        hit
);

    logic [QUAL_W-1:0] cnt_r;
    logic              match_s;

    // ABOVE=1 qualifies samples strictly above THR, otherwise at or below
    always_comb begin
        match_s = 1'b0;
        if (ABOVE) begin
            match_s = (sample > THR);
        end else begin
            match_s = (sample <= THR);
        end
    end

    assign hit = sample_vld && match_s && (cnt_r == QUAL_W'(CNT - 1));

    // Consecutive-run counter, saturating at all-ones
    always_ff @(posedge clk) begin
        if (nrst || clr) begin
            cnt_r <= {QUAL_W{1'b0}};
        end else if (sample_vld) begin
            if (!match_s) begin
                cnt_r <= {QUAL_W{1'b0}};
            end else if (cnt_r != {QUAL_W{1'b1}}) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// SWIPT receive PLL power-up / settle / acquire / lock supervisor.
// Define PLL_SEQ_FREQ_CHECK_EN to treat out-of-range f_pll as an acquisition timeout.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int          SETTLE_CYC  = 1250,
    parameter int          TIMEOUT_CYC = 200000,
    parameter logic [31:0] LOCK_THR    = 32'd50,
    parameter logic [31:0] UNLOCK_THR  = 32'd200,
    parameter int          LOCK_CNT    = 8,
    parameter int          MAX_RETRY   = 3,
    parameter logic [31:0] F_MIN       = 32'd30000,
    parameter logic [31:0] F_MAX       = 32'd60000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swipt_alive,
    input  logic [31:0] phase_err,
    input  logic        phase_vld,
    input  logic [31:0] f_pll,
    input  logic        clr_fault,
    output logic        pll_en,
    output logic        freq_rdy,
    output logic        locked,
    output logic        fault,
    output logic [1:0]  retry_cnt,
    output logic [2:0]  state
);

    localparam logic [CNT_W-1:0]   SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    pll_state_t         state_r, state_n;
    logic [CNT_W-1:0]   settle_r, settle_n, tmo_r, tmo_n;
    logic [RETRY_W-1:0] retry_r, retry_n;
    logic pll_en_r, pll_en_n, freq_rdy_r, freq_rdy_n;
    logic locked_r, locked_n, fault_r, fault_n;
    logic good_hit_s, bad_hit_s, good_clr_s, bad_clr_s;
    logic freq_bad_s, timeout_s;

`ifdef PLL_SEQ_FREQ_CHECK_EN
    assign freq_bad_s = (f_pll < F_MIN) || (f_pll > F_MAX);
`else
    logic freq_unused_s;
    assign freq_unused_s = ^{f_pll, F_MIN, F_MAX};
    assign freq_bad_s    = 1'b0;
`endif

    assign good_clr_s = (state_r != ST_ACQUIRE) || !swipt_alive;
    assign bad_clr_s  = (state_r != ST_LOCKED) || !swipt_alive;
    assign timeout_s  = ((state_r == ST_ACQUIRE) && (tmo_r == {CNT_W{1'b0}})) ||
                        (((state_r == ST_ACQUIRE) || (state_r == ST_LOCKED)) && freq_bad_s);

    lock_qualifier #(.THR(LOCK_THR), .CNT(LOCK_CNT), .ABOVE(1'b0)) u_good (
        .clk(clk), .nrst(nrst), .clr(good_clr_s),
        .sample_vld(phase_vld), .sample(phase_err), .hit(good_hit_s)
    );

    lock_qualifier #(.THR(UNLOCK_THR), .CNT(LOCK_CNT), .ABOVE(1'b1)) u_bad (
        .clk(clk), .nrst(nrst), .clr(bad_clr_s),
        .sample_vld(phase_vld), .sample(phase_err), .hit(bad_hit_s)
    );

    // Next-state, counter and output decode; link loss outranks everything but FAULT
    always_comb begin
        state_n    = state_r;
        settle_n   = settle_r;
        tmo_n      = tmo_r;
        retry_n    = retry_r;
        pll_en_n   = 1'b0;
        freq_rdy_n = 1'b0;
        locked_n   = 1'b0;
        fault_n    = 1'b0;
        if (!swipt_alive && (state_r != ST_FAULT)) begin
            state_n  = ST_IDLE;
            settle_n = {CNT_W{1'b0}};
            tmo_n    = {CNT_W{1'b0}};
            retry_n  = {RETRY_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n  = ST_SETTLE;
                    settle_n = SETTLE_LD;
                end
                ST_SETTLE: begin
                    if (settle_r == {CNT_W{1'b0}}) begin
                        state_n = ST_ACQUIRE;
                        tmo_n   = TIMEOUT_LD;
                    end else begin
                        settle_n = dec_sat(settle_r);
                    end
                end
                ST_ACQUIRE, ST_LOCKED: begin
                    // Lock qualification outranks a coincident timeout
                    if ((state_r == ST_ACQUIRE) && good_hit_s) begin
                        state_n = ST_LOCKED;
                    end else if ((state_r == ST_LOCKED) && bad_hit_s) begin
                        state_n = ST_ACQUIRE;
                        tmo_n   = TIMEOUT_LD;
                    end else if (timeout_s) begin
                        if (retry_r >= RETRY_MAX) begin
                            state_n = ST_FAULT;
                        end else begin
                            state_n  = ST_SETTLE;
                            settle_n = SETTLE_LD;
                            retry_n  = retry_r + 2'd1;
                        end
                    end else begin
                        tmo_n = (state_r == ST_ACQUIRE) ? dec_sat(tmo_r) : tmo_r;
                    end
                end
                ST_FAULT: begin
                    if (clr_fault) begin
                        state_n = ST_IDLE;
                        retry_n = {RETRY_W{1'b0}};
                    end else begin
                        state_n = ST_FAULT;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        case (state_n)
            ST_SETTLE: begin
                pll_en_n   = 1'b1;
                freq_rdy_n = 1'b1;
            end
            ST_ACQUIRE: begin
                pll_en_n = 1'b1;
            end
            ST_LOCKED: begin
                pll_en_n = 1'b1;
                locked_n = 1'b1;
            end
            ST_FAULT: begin
                fault_n = 1'b1;
            end
            default: begin
                pll_en_n = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_r    <= ST_IDLE;
            settle_r   <= {CNT_W{1'b0}};
            tmo_r      <= {CNT_W{1'b0}};
            retry_r    <= {RETRY_W{1'b0}};
            pll_en_r   <= 1'b0;
            freq_rdy_r <= 1'b0;
            locked_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_n;
            settle_r   <= settle_n;
            tmo_r      <= tmo_n;
            retry_r    <= retry_n;
            pll_en_r   <= pll_en_n;
            freq_rdy_r <= freq_rdy_n;
            locked_r   <= locked_n;
            fault_r    <= fault_n;
        end
    end

    assign pll_en    = pll_en_r;
    assign freq_rdy  = freq_rdy_r;
    assign locked    = locked_r;
    assign fault     = fault_r;
    assign retry_cnt = retry_r;
    assign state     = state_r;

endmodule
